adder_seq_chunked: RTL and testbench
====================================

Name: adder_seq_chunked

Overview:
- Parametrised, multi-cycle successor to the fixed 16-bit combinational adder used in the mul32 datapath.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, holding the carry in a register between chunks.
- Uses valid/ready handshakes on input and output, so the multiplier's partial-product accumulator can share one narrow adder slice across wide words.
- Carry-out is presented zero-extended to 8 bits, matching the existing adder's carry byte format.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits processed per cycle; CHUNK == WIDTH gives single-cycle operation.
- NCHUNK, WIDTH/CHUNK, derived; number of RUN cycles; not user-overridden.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset; rst=0 clears all state immediately.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (borrow-in when sub=1).
- sub  input  1  0: A+B+cin; 1: A-B-cin.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  8  {7'b0, carry}; carry is raw adder carry (for sub: 1 = no borrow).
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset (rst=0, async): state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, chunk index=0, carry reg=0.
- States: IDLE, RUN, DONE.
- in_ready=1 only in IDLE; out_valid=1 only in DONE.
- IDLE: on in_valid & in_ready at an edge:
  - latch a, and b' = sub ? ~b : b;
  - carry reg = cin ^ sub;
  - latch sub; index=0; go to RUN.
  - a/b/cin/sub are don't-care at all other times.
- RUN: each cycle, chunk[index] = a_chunk + b'_chunk + carry.
  - Low CHUNK bits written to sum[index*CHUNK +: CHUNK].
  - Carry reg updated from the chunk carry; index++.
  - After chunk NCHUNK-1: record final carry, compute ovf = carry into MSB XOR carry out of MSB; go to DONE.
- Latency: operands accepted at edge k; out_valid=1 from edge k+NCHUNK. NCHUNK=1 gives out_valid one cycle after accept.
- DONE: sum/cout/ovf stable while out_valid=1.
  - On out_valid & out_ready: go to IDLE; out_valid drops next cycle.
  - Outputs retain their last values in IDLE; consumers must qualify with out_valid.
- Backpressure: out_ready=0 holds DONE indefinitely, with no change to outputs. in_valid is ignored outside IDLE; no input buffering.
- Throughput: one operation per NCHUNK+2 cycles minimum (accept, NCHUNK RUN, DONE handshake).
- Reset mid-RUN or mid-DONE aborts the operation with no output. The post-reset state equals the reset values above, and the first edge after rst=1 may accept new operands.
- Wrap-around: sum is mod 2^WIDTH; overflow is reported only via carry and ovf, never saturated.
- Sub mode with cin=1: A-B-1, carry reg seeded 0.

Test Plan:
- WIDTH=32, CHUNK=8: a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> out_valid exactly 4 cycles after accept; sum=0x00000000, cout=0x01, ovf=0.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001, sub=0 -> sum=0x80000000, cout=0x00, ovf=1. Then a=0x80000000, b=0x00000001, sub=1 -> sum=0x7FFFFFFF, cout=0x01, ovf=1.
- Subtract/borrow: a=5, b=7, sub=1, cin=0 -> sum=0xFFFFFFFE, cout=0x00, ovf=0. Same with cin=1 -> sum=0xFFFFFFFD.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs constant, in_ready=0, a second in_valid is ignored. Release -> one transfer, then in_ready=1 next cycle.
- Reset mid-op: assert rst=0 asynchronously at RUN index 2 -> out_valid=0, in_ready=1 immediately. After release, a=1, b=2 -> sum=3 with normal latency.
- Degenerate config WIDTH=16, CHUNK=16: a=0xFFFF, b=0x0001, cin=1 -> sum=0x0001, cout=0x01, out_valid 1 cycle after accept. Random 16-bit vectors must match a combinational 16-bit add.

Source files
------------

// File: rtl/adder_seq_chunked.sv
// -----------------------------------------------------------------------------
// adder_seq_chunked
//   Multi-cycle add/subtract unit. Processes a WIDTH-bit operand pair CHUNK bits
//   per clock, carrying between chunks in a register, with valid/ready
//   handshakes on both sides.
//
// Parameters
//   WIDTH      operand/result width (multiple of CHUNK)
//   CHUNK      bits processed per RUN cycle (CHUNK == WIDTH -> one RUN cycle)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   in_valid   operands valid            in_ready   accepting operands (IDLE)
//   a, b       operands                  cin        carry-in / borrow-in
//   sub        0: a+b+cin, 1: a-b-cin
//   out_valid  result valid (DONE)       out_ready  consumer accepts result
//   sum        result mod 2^WIDTH
//   cout       {7'b0, carry}; for subtract carry=1 means no borrow
//   ovf        signed two's-complement overflow
// -----------------------------------------------------------------------------
module adder_seq_chunked #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic [7:0]       cout,
   output logic             ovf
);

   localparam int unsigned NCHUNK = WIDTH / CHUNK;
   localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   generate
      if ((CHUNK == 0) || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
         $error("adder_seq_chunked: WIDTH must be a non-zero multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t            r_state;
   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;
   logic              r_carry;
   logic [IDXW-1:0]   r_idx;
   logic [WIDTH-1:0]  r_sum;
   logic [7:0]        r_cout;
   logic              r_ovf;
   logic              r_in_ready;
   logic              r_out_valid;

   logic [CHUNK-1:0]  w_a_chunk;
   logic [CHUNK-1:0]  w_b_chunk;
   logic [CHUNK:0]    w_chunk_sum;
   logic              w_carry_into_msb;
   logic              w_last;

   // Operand registers are shifted right one chunk per RUN cycle, so the
   // active chunk is always in the low CHUNK bits.
   assign w_a_chunk   = r_a[CHUNK-1:0];
   assign w_b_chunk   = r_b[CHUNK-1:0];
   assign w_chunk_sum = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};

   // Carry into the top bit of the chunk, recovered from the sum bit:
   // s = a ^ b ^ c_in  =>  c_in = a ^ b ^ s.  Only meaningful on the last chunk.
   assign w_carry_into_msb = w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1] ^ w_chunk_sum[CHUNK-1];
   assign w_last           = (r_idx == IDXW'(NCHUNK - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_carry     <= 1'b0;
         r_idx       <= '0;
         r_sum       <= '0;
         r_cout      <= '0;
         r_ovf       <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid && r_in_ready) begin
                  // Subtraction is a + ~b + 1; a borrow-in removes that +1.
                  r_a        <= a;
                  r_b        <= sub ? ~b : b;
                  r_carry    <= cin ^ sub;
                  r_idx      <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= S_RUN;
               end
            end

            S_RUN: begin
               for (int unsigned i = 0; i < NCHUNK; i++) begin
                  if (r_idx == IDXW'(i)) begin
                     r_sum[i*CHUNK +: CHUNK] <= w_chunk_sum[CHUNK-1:0];
                  end
               end
               r_a     <= r_a >> CHUNK;
               r_b     <= r_b >> CHUNK;
               r_carry <= w_chunk_sum[CHUNK];
               r_idx   <= r_idx + IDXW'(1);
               if (w_last) begin
                  r_cout      <= {7'b0, w_chunk_sum[CHUNK]};
                  r_ovf       <= w_carry_into_msb ^ w_chunk_sum[CHUNK];
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end
            end

            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end

            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign sum       = r_sum;
   assign cout      = r_cout;
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_adder_seq_chunked.sv
// -----------------------------------------------------------------------------
// tb_adder_seq_chunked
//   Scoreboard bench for adder_seq_chunked in two configurations:
//   WIDTH=32/CHUNK=8 and WIDTH=16/CHUNK=16. Drivers push expected results from
//   an arithmetic reference model; monitors pop and compare on each output
//   transfer.
// -----------------------------------------------------------------------------
module tb_adder_seq_chunked;

   typedef struct packed {
      logic [63:0] sum;
      logic [7:0]  cout;
      logic        ovf;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 32-bit / 8-bit chunk instance
   logic        rst1, in_valid1, in_ready1, cin1, sub1, out_valid1, out_ready1, ovf1;
   logic [31:0] a1, b1, sum1;
   logic [7:0]  cout1;

   // 16-bit single-chunk instance
   logic        rst2, in_valid2, in_ready2, cin2, sub2, out_valid2, out_ready2, ovf2;
   logic [15:0] a2, b2, sum2;
   logic [7:0]  cout2;

   adder_seq_chunked #(.WIDTH(32), .CHUNK(8)) u_dut32 (
      .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1), .cin(cin1), .sub(sub1),
      .out_valid(out_valid1), .out_ready(out_ready1),
      .sum(sum1), .cout(cout1), .ovf(ovf1)
   );

   adder_seq_chunked #(.WIDTH(16), .CHUNK(16)) u_dut16 (
      .clk(clk), .rst(rst2), .in_valid(in_valid2), .in_ready(in_ready2),
      .a(a2), .b(b2), .cin(cin2), .sub(sub2),
      .out_valid(out_valid2), .out_ready(out_ready2),
      .sum(sum2), .cout(cout2), .ovf(ovf2)
   );

   int   n_checks = 0;
   int   n_fail   = 0;
   logic rand_bp  = 1'b0;
   exp_t q32[$];
   exp_t q16[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer arithmetic on w-bit values, unsigned for sum and
   // carry, signed for overflow.
   function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input logic cin, input logic sub);
      exp_t   e;
      longint full, half, ua, ub, sa, sb, c, ures, sres;
      full = longint'(1) << w;
      half = full >> 1;
      ua   = longint'(a) & (full - 1);
      ub   = longint'(b) & (full - 1);
      sa   = (ua >= half) ? ua - full : ua;
      sb   = (ub >= half) ? ub - full : ub;
      c    = cin ? 1 : 0;
      if (sub) begin
         ures   = ua - ub - c;
         sres   = sa - sb - c;
         e.cout = (ures >= 0) ? 8'd1 : 8'd0;
      end else begin
         ures   = ua + ub + c;
         sres   = sa + sb + c;
         e.cout = (ures >= full) ? 8'd1 : 8'd0;
      end
      e.sum = 64'(ures & (full - 1));
      e.ovf = (sres >= half) || (sres < -half);
      return e;
   endfunction

   // Issue one operation; exp_lat > 0 also measures accept-to-out_valid cycles.
   task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic cin,
                       input logic sub, input int exp_lat);
      int waited;
      int lat;
      in_valid1 = 1'b1; a1 = a; b1 = b; cin1 = cin; sub1 = sub;
      waited = 0;
      @(negedge clk);
      while (!in_ready1 && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready1) begin
         n_checks++; n_fail++;
         $display("FAIL accept_timeout32: in_ready got 0 required 1 within 100 cycles");
         in_valid1 = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      in_valid1 = 1'b0;
      q32.push_back(model(32, 64'(a), 64'(b), cin, sub));
      if (exp_lat > 0) begin
         lat = 0;
         while (!out_valid1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
         end
         check("latency32", 64'(lat), 64'(exp_lat));
      end
   endtask

   task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic sub, input int exp_lat);
      int waited;
      int lat;
      in_valid2 = 1'b1; a2 = a; b2 = b; cin2 = cin; sub2 = sub;
      waited = 0;
      @(negedge clk);
      while (!in_ready2 && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready2) begin
         n_checks++; n_fail++;
         $display("FAIL accept_timeout16: in_ready got 0 required 1 within 100 cycles");
         in_valid2 = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      in_valid2 = 1'b0;
      q16.push_back(model(16, 64'(a), 64'(b), cin, sub));
      if (exp_lat > 0) begin
         lat = 0;
         while (!out_valid2 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
         end
         check("latency16", 64'(lat), 64'(exp_lat));
      end
   endtask

   // Monitors: sample on the falling edge, i.e. what the next rising edge sees.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst1 && out_valid1 && out_ready1) begin
            if (q32.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_out32: got sum 0x%0h with no operation pending", sum1);
            end else begin
               e = q32.pop_front();
               check("sum32", 64'(sum1), e.sum);
               check("cout32", 64'(cout1), 64'(e.cout));
               check("ovf32", 64'(ovf1), 64'(e.ovf));
            end
         end
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst2 && out_valid2 && out_ready2) begin
            if (q16.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_out16: got sum 0x%0h with no operation pending", sum2);
            end else begin
               e = q16.pop_front();
               check("sum16", 64'(sum2), e.sum);
               check("cout16", 64'(cout2), 64'(e.cout));
               check("ovf16", 64'(ovf2), 64'(e.ovf));
            end
         end
      end
   end

   // Random consumer backpressure.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_bp) begin
            out_ready1 = 1'($urandom_range(0, 1));
            out_ready2 = 1'($urandom_range(0, 1));
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t        e;
      logic [31:0] corners32 [4];
      logic [31:0] ra, rb;
      int          t;
      corners32[0] = 32'h0000_0000; corners32[1] = 32'hFFFF_FFFF;
      corners32[2] = 32'h7FFF_FFFF; corners32[3] = 32'h8000_0000;

      rst1 = 1'b0; rst2 = 1'b0;
      in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0; out_ready1 = 1'b1;
      in_valid2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0; sub2 = 1'b0; out_ready2 = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready32", 64'(in_ready1), 64'd1);
      check("rst_out_valid32", 64'(out_valid1), 64'd0);
      check("rst_sum32", 64'(sum1), 64'd0);
      check("rst_cout32", 64'(cout1), 64'd0);
      check("rst_ovf32", 64'(ovf1), 64'd0);
      check("rst_in_ready16", 64'(in_ready2), 64'd1);
      check("rst_out_valid16", 64'(out_valid2), 64'd0);
      check("rst_sum16", 64'(sum2), 64'd0);
      @(negedge clk);
      rst1 = 1'b1; rst2 = 1'b1;
      @(posedge clk);
      #1;

      // Directed cases, each with latency measurement
      op32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4);
      op32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4);
      op32(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 4);
      op32(32'd5, 32'd7, 1'b0, 1'b1, 4);
      op32(32'd5, 32'd7, 1'b1, 1'b1, 4);

      // Backpressure: result held 10 cycles, second request ignored
      repeat (3) @(posedge clk);
      #1;
      out_ready1 = 1'b0;
      op32(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 4);
      e = model(32, 64'h1234_5678, 64'h0FED_CBA9, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         check("bp_out_valid", 64'(out_valid1), 64'd1);
         check("bp_in_ready", 64'(in_ready1), 64'd0);
         check("bp_sum", 64'(sum1), e.sum);
         check("bp_cout", 64'(cout1), 64'(e.cout));
         check("bp_ovf", 64'(ovf1), 64'(e.ovf));
         in_valid1 = 1'b1; a1 = $urandom; b1 = $urandom;
         @(posedge clk);
         #1;
      end
      in_valid1  = 1'b0;
      out_ready1 = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release_out_valid", 64'(out_valid1), 64'd0);
      check("bp_release_in_ready", 64'(in_ready1), 64'd1);
      repeat (6) begin
         @(posedge clk);
         #1;
         check("bp_no_extra_out", 64'(out_valid1), 64'd0);
      end
      check("bp_queue_empty", 64'(q32.size()), 64'd0);

      // Asynchronous reset while RUN is on chunk index 2
      op32(32'hAAAA_5555, 32'h1357_9BDF, 1'b0, 1'b0, 0);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst1 = 1'b0;
      #1;
      check("midrst_out_valid", 64'(out_valid1), 64'd0);
      check("midrst_in_ready", 64'(in_ready1), 64'd1);
      check("midrst_sum", 64'(sum1), 64'd0);
      check("midrst_cout", 64'(cout1), 64'd0);
      void'(q32.pop_back());
      @(negedge clk);
      rst1 = 1'b1;
      @(posedge clk);
      #1;
      op32(32'd1, 32'd2, 1'b0, 1'b0, 4);

      // Degenerate single-chunk configuration
      op16(16'hFFFF, 16'h0001, 1'b1, 1'b0, 1);
      op16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1);
      op16(16'h8000, 16'h0001, 1'b0, 1'b1, 1);

      // Random traffic with random consumer stalls
      rand_bp = 1'b1;
      for (int i = 0; i < 200; i++) begin
         ra = ($urandom_range(0, 3) == 0) ? corners32[$urandom_range(0, 3)] : 32'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? corners32[$urandom_range(0, 3)] : 32'($urandom);
         op32(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      end
      for (int i = 0; i < 150; i++) begin
         op16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      end

      // Drain outstanding results
      @(posedge clk);
      #1;
      rand_bp    = 1'b0;
      out_ready1 = 1'b1;
      out_ready2 = 1'b1;
      t = 0;
      while ((q32.size() != 0 || q16.size() != 0) && t < 200) begin
         @(posedge clk);
         t++;
      end
      #1;
      check("drain_q32", 64'(q32.size()), 64'd0);
      check("drain_q16", 64'(q16.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
